// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART serial transmitter. Start bit, 5-8 data bits LSB first,
//            optional even parity, 1 or 2 stop bits. Bit timing is driven by
//            baud ticks from the shared baud generator (16x or 13x).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int OSR_16 = 16,
    parameter int OSR_13 = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_clk,
    input  logic       BGE,
    input  logic       OSM_SEL,
    input  logic       PEN,
    input  logic       STB,
    input  logic [1:0] WLS,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       UART_TX_O
);

    // Tick counter compares against N-1: the bit ends in the cycle holding the
    // N-th tick, so a 4-bit counter suffices for N up to 16.
    localparam logic [3:0] C_LAST_16 = 4'(OSR_16 - 1);
    localparam logic [3:0] C_LAST_13 = 4'(OSR_13 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_shift;      // shadow copy of the character, shifted as sent
    logic       r_pen;        // latched frame configuration
    logic       r_stb;
    logic       r_osm;
    logic [1:0] r_wls;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic       r_stop_cnt;
    logic       r_parity;     // running XOR of data bits already sent
    logic       r_line;
    logic       r_done;

    logic       w_tick;
    logic [3:0] w_last_tick;
    logic       w_bit_end;
    logic       w_last_data;
    logic       w_accept;

    // Tick qualification and bit-end detection from the latched configuration
    always_comb begin
        w_tick      = baud_clk & BGE;
        w_last_tick = r_osm ? C_LAST_13 : C_LAST_16;
        w_bit_end   = w_tick && (r_tick_cnt == w_last_tick) && (r_state != IDLE);
        // Last data bit index is W-1 = 4 + WLS
        w_last_data = (r_bit_cnt == {1'b1, r_wls});
        tx_ready    = (r_state == IDLE) & BGE;
        w_accept    = tx_ready & tx_start;
    end

    assign tx_done   = r_done;
    assign UART_TX_O = r_line;

    // Frame sequencer: state, counters, shadow register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= 8'd0;
            r_pen      <= 1'b0;
            r_stb      <= 1'b0;
            r_osm      <= 1'b0;
            r_wls      <= 2'd0;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_line     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Ticks are only counted while a frame is in flight; BGE low
            // freezes the counter and therefore the whole frame.
            if ((r_state != IDLE) && w_tick) begin
                r_tick_cnt <= w_bit_end ? 4'd0 : r_tick_cnt + 4'd1;
            end

            case (r_state)
                IDLE: begin
                    r_line <= 1'b1;
                    if (w_accept) begin
                        r_shift    <= tx_data;
                        r_pen      <= PEN;
                        r_stb      <= STB;
                        r_wls      <= WLS;
                        r_osm      <= OSM_SEL;
                        r_tick_cnt <= 4'd0;
                        r_bit_cnt  <= 3'd0;
                        r_stop_cnt <= 1'b0;
                        r_parity   <= 1'b0;
                        r_line     <= 1'b0;
                        r_state    <= START;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_line  <= r_shift[0];
                        r_state <= DATA;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_parity <= r_parity ^ r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                        if (w_last_data) begin
                            r_bit_cnt <= 3'd0;
                            if (r_pen) begin
                                r_line  <= r_parity ^ r_shift[0];
                                r_state <= PARITY;
                            end else begin
                                r_line  <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_line    <= r_shift[1];
                        end
                    end
                end

                PARITY: begin
                    if (w_bit_end) begin
                        r_line  <= 1'b1;
                        r_state <= STOP;
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        if (r_stb && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b0;
                            r_line     <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end

                default: begin
                    r_line  <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx. Stimulus pushes hand-computed line
//            sequences; a monitor decodes the TX line by counting baud ticks
//            and compares every tick cycle and the tx_done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_clk = 1'b0;
    logic       BGE;
    logic       OSM_SEL;
    logic       PEN;
    logic       STB;
    logic [1:0] WLS;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       UART_TX_O;

    uart_tx #(.OSR_16(16), .OSR_13(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_clk  (baud_clk),
        .BGE       (BGE),
        .OSM_SEL   (OSM_SEL),
        .PEN       (PEN),
        .STB       (STB),
        .WLS       (WLS),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .UART_TX_O (UART_TX_O)
    );

    always #5 clk = ~clk;

    // Baud tick every 5 clk
    int div_cnt = 0;
    always @(posedge clk) begin
        if (div_cnt == 4) begin
            div_cnt  <= 0;
            baud_clk <= 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1;
            baud_clk <= 1'b0;
        end
    end

    typedef struct {
        logic [15:0] bits;   // bit i = i-th level on the line
        int          len;    // number of bits in the frame
        int          n;      // ticks per bit
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: frame decoder driven by qualified ticks
    // ------------------------------------------------------------------
    bit   mon_busy  = 1'b0;
    bit   mon_await = 1'b0;
    int   mon_tick  = 0;
    int   mon_idx   = 0;
    int   mon_done_cnt = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            mon_busy  = 1'b0;
            mon_await = 1'b0;
        end else begin
            if (mon_await) begin
                mon_await = 1'b0;
                chk("done_pulse", tx_done, 1'b1);
                chk("done_line", UART_TX_O, 1'b1);
            end else begin
                chk("done_quiet", tx_done, 1'b0);
            end
            if (tx_done) mon_done_cnt++;

            if (!mon_busy && UART_TX_O == 1'b0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got start bit expected idle at %0t", $time);
                    cur = '{bits: 16'hFFFF, len: 12, n: 16};
                end else begin
                    cur = sb.pop_front();
                end
                mon_busy = 1'b1;
                mon_tick = 0;
            end

            if (mon_busy && baud_clk && BGE) begin
                mon_tick++;
                mon_idx = (mon_tick - 1) / cur.n;
                chk($sformatf("bit%0d", mon_idx), UART_TX_O, cur.bits[mon_idx]);
                if (mon_tick == cur.len * cur.n) begin
                    mon_busy  = 1'b0;
                    mon_await = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cfg(input logic osm, input logic pen, input logic stb, input logic [1:0] wls);
        @(posedge clk);
        #1;
        OSM_SEL = osm;
        PEN     = pen;
        STB     = stb;
        WLS     = wls;
    endtask

    task automatic send(input logic [7:0] d, output time acc_t);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        tx_start = 1'b1;
        tx_data  = d;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got tx_ready=0 expected 1 within 5000 clk");
        end
        @(posedge clk);
        acc_t = $time;
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(output time t);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (tx_done) begin
                t = $time;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL done_timeout: got no tx_done expected one within 5000 clk");
        t = $time;
    endtask

    task automatic chk_len(input string name, input time t_acc, input time t_done, input int want);
        int dur;
        dur = int'((t_done - 5 - t_acc) / 10);
        total++;
        if (dur < want - 5 || dur > want + 5) begin
            bad++;
            $display("FAIL %s: got %0d clk expected %0d +/- 5", name, dur, want);
        end
    endtask

    // Loopback-style character table (8N1, 16x): data and hand-computed line bits
    logic [7:0]  lb_data [5] = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h3C};
    logic [15:0] lb_bits [5] = '{16'h0200, 16'h02AA, 16'h0354, 16'h03FE, 16'h0278};

    time ta, td;

    initial begin
        rst      = 1'b1;
        BGE      = 1'b0;
        OSM_SEL  = 1'b0;
        PEN      = 1'b0;
        STB      = 1'b0;
        WLS      = 2'b11;
        tx_start = 1'b0;
        tx_data  = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_line", UART_TX_O, 1'b1);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_ready_bge0", tx_ready, 1'b0);
        @(posedge clk);
        #1 BGE = 1'b1;
        @(negedge clk);
        chk("rst_ready_bge1", tx_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        // 8 data bits, even parity, 2 stop bits, 16x: 0xA5
        cfg(1'b0, 1'b1, 1'b1, 2'b11);
        sb.push_back('{bits: 16'h0D4A, len: 12, n: 16});
        send(8'hA5, ta);
        @(negedge clk);
        chk("busy_ready", tx_ready, 1'b0);
        chk("start_fall", UART_TX_O, 1'b0);
        wait_done(td);
        chk("done_ready", tx_ready, 1'b1);
        chk_len("len_8e2", ta, td, 960);

        // 5 data bits, parity, 1 stop bit, 13x: 0xFF
        cfg(1'b1, 1'b1, 1'b0, 2'b00);
        sb.push_back('{bits: 16'h00FE, len: 8, n: 13});
        send(8'hFF, ta);
        wait_done(td);
        chk_len("len_5e1_13x", ta, td, 520);

        // Back-to-back with tx_start held high: 0x00 then 0xFF, 8N1
        cfg(1'b0, 1'b0, 1'b0, 2'b11);
        sb.push_back('{bits: 16'h0200, len: 10, n: 16});
        sb.push_back('{bits: 16'h03FE, len: 10, n: 16});
        send(8'h00, ta);
        #0;
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        wait_done(td);
        chk("b2b_ready_in_done", tx_ready, 1'b1);
        @(posedge clk);
        #1 tx_start = 1'b0;
        @(negedge clk);
        chk("b2b_start_no_gap", UART_TX_O, 1'b0);
        wait_done(td);

        // BGE pause of 200 clk mid-data, 8E2 16x: 0x3C
        cfg(1'b0, 1'b1, 1'b1, 2'b11);
        sb.push_back('{bits: 16'h0C78, len: 12, n: 16});
        send(8'h3C, ta);
        repeat (300) @(posedge clk);
        #1 BGE = 1'b0;
        @(negedge clk);
        chk("pause_line_begin", UART_TX_O, 1'b1);
        repeat (199) @(posedge clk);
        @(negedge clk);
        chk("pause_line_end", UART_TX_O, 1'b1);
        @(posedge clk);
        #1 BGE = 1'b1;
        wait_done(td);
        chk_len("len_paused", ta, td, 1160);

        // Reset during the parity bit, then a clean 0x3C frame
        sb.push_back('{bits: 16'h0D4A, len: 12, n: 16});
        send(8'hA5, ta);
        repeat (760) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_line", UART_TX_O, 1'b1);
        chk("midrst_done", tx_done, 1'b0);
        chk("midrst_ready", tx_ready, 1'b1);
        sb.push_back('{bits: 16'h0C78, len: 12, n: 16});
        send(8'h3C, ta);
        wait_done(td);

        // Character table, 8N1 16x
        cfg(1'b0, 1'b0, 1'b0, 2'b11);
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{bits: lb_bits[k], len: 10, n: 16});
            send(lb_data[k], ta);
            wait_done(td);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("mon_idle", {31'd0, mon_busy}, 0);
        chk("done_count", mon_done_cnt, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
